// File: rtl/matmul_mul_share_arbiter.sv
// Shared 33x30 -> 63-bit unsigned multiplier with round-robin arbitration
// among NUM_REQ requesters. The result lands in a single registered,
// back-pressurable slot tagged with the winning requester index.
//
// Handshake semantics (requester side and result side):
//   A requester transfer happens in a cycle where req_valid[i] and req_ready[i]
//   are both high. req_ready is one-hot or zero and is derived combinationally
//   from req_valid and res_ready, so req_valid must never depend on req_ready.
//   A result transfer happens in a cycle where res_valid and res_ready are both
//   high. While res_valid is high and res_ready is low, res_data and res_id
//   are held stable.
module matmul_mul_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*33-1:0] req_a,
   input  logic [NUM_REQ*30-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  res_valid,
   output logic [62:0]           res_data,
   output logic [ID_W-1:0]       res_id,
   input  logic                  res_ready,
   output logic [CNT_W-1:0]      issue_count,
   output logic                  dbg_state,
   output logic [ID_W-1:0]       dbg_rr_ptr
);

   localparam int A_W = 33;
   localparam int B_W = 30;

   // Slot FSM: EMPTY holds no product, FULL holds one awaiting consumption.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [62:0]      res_data_q, res_data_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] issue_count_q, issue_count_d;

   logic             win_found;
   logic [ID_W-1:0]  win_idx;
   int               scan_idx;
   logic             slot_free;
   logic             issue;
   logic [A_W-1:0]   a_sel;
   logic [B_W-1:0]   b_sel;
   logic [62:0]      product;

   // Round-robin search: first valid requester starting at rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(scan_idx);
         end
      end
   end

   // Only the winner's operands are muxed in, so unselected X operands never
   // propagate into the product.
   assign a_sel   = req_a[int'(win_idx)*A_W +: A_W];
   assign b_sel   = req_b[int'(win_idx)*B_W +: B_W];
   assign product = {30'b0, a_sel} * {33'b0, b_sel};

   // Issue whenever someone is valid and the slot is empty or being drained.
   assign slot_free = (state_q == ST_EMPTY) || res_ready;
   assign issue     = win_found && slot_free && !ap_rst;
   assign req_ready = issue ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

   // Next-state: refill on issue (even while draining), otherwise drain on consume.
   always_comb begin
      state_d       = state_q;
      res_data_d    = res_data_q;
      res_id_d      = res_id_q;
      rr_ptr_d      = rr_ptr_q;
      issue_count_d = issue_count_q;
      if (issue) begin
         state_d       = ST_FULL;
         res_data_d    = product;
         res_id_d      = win_idx;
         rr_ptr_d      = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
         issue_count_d = issue_count_q + CNT_W'(1);
      end else if (res_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q       <= ST_EMPTY;
         res_data_q    <= '0;
         res_id_q      <= '0;
         rr_ptr_q      <= '0;
         issue_count_q <= '0;
      end else begin
         state_q       <= state_d;
         res_data_q    <= res_data_d;
         res_id_q      <= res_id_d;
         rr_ptr_q      <= rr_ptr_d;
         issue_count_q <= issue_count_d;
      end
   end

   assign res_valid   = (state_q == ST_FULL);
   assign res_data    = res_data_q;
   assign res_id      = res_id_q;
   assign issue_count = issue_count_q;
   assign dbg_state   = state_q;
   assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_matmul_mul_share_arbiter.sv
// Directed bench for the shared-multiplier arbiter. A second instance with a
// 4-bit issue counter shares the same stimulus to observe counter wrap.
module tb_matmul_mul_share_arbiter;

   logic          ap_clk;
   logic          ap_rst;
   logic [3:0]    req_valid;
   logic [131:0]  req_a;
   logic [119:0]  req_b;
   logic          res_ready;

   logic [3:0]    req_ready,  req_ready4;
   logic          res_valid,  res_valid4;
   logic [62:0]   res_data,   res_data4;
   logic [1:0]    res_id,     res_id4;
   logic [31:0]   issue_count;
   logic [3:0]    issue_count4;
   logic          dbg_state,  dbg_state4;
   logic [1:0]    dbg_rr_ptr, dbg_rr_ptr4;

   logic [32:0]   a_v [4];
   logic [29:0]   b_v [4];

   int            total;
   int            bad;
   int            exp_cnt;
   int            exp_ptr;

   matmul_mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(32)) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
      .res_ready(res_ready), .issue_count(issue_count),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   matmul_mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) u_dut4 (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready4),
      .res_valid(res_valid4), .res_data(res_data4), .res_id(res_id4),
      .res_ready(res_ready), .issue_count(issue_count4),
      .dbg_state(dbg_state4), .dbg_rr_ptr(dbg_rr_ptr4)
   );

   // Clock
   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   // Operand packing
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         req_a[i*33 +: 33] = a_v[i];
         req_b[i*30 +: 30] = b_v[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // One expected issue to requester w with inputs already driven.
   task automatic issue_step(input int w, input string tag);
      logic [62:0] e;
      logic [3:0]  g;
      e = {30'b0, a_v[w]} * {33'b0, b_v[w]};
      g = 4'b0001 << w;
      #1;
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(g));
      tick();
      exp_cnt++;
      exp_ptr = (w == 3) ? 0 : w + 1;
      chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_res_id"}, 64'(res_id), 64'(w));
      chk({tag, "_res_data"}, 64'(res_data), 64'(e));
      chk({tag, "_count"}, 64'(issue_count), 64'(exp_cnt));
      chk({tag, "_count4"}, 64'(issue_count4), 64'(exp_cnt % 16));
      chk({tag, "_rr_ptr"}, 64'(dbg_rr_ptr), 64'(exp_ptr));
   endtask

   initial begin
      total = 0; bad = 0; exp_cnt = 0; exp_ptr = 0;
      for (int i = 0; i < 4; i++) begin
         a_v[i] = '0;
         b_v[i] = '0;
      end
      ap_rst    = 1'b1;
      req_valid = 4'hF;
      res_ready = 1'b1;

      // Reset state; req_ready forced low even with all valid
      #22;
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_res_id", 64'(res_id), 64'd0);
      chk("rst_count", 64'(issue_count), 64'd0);
      chk("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      req_valid = 4'h0;
      ap_rst    = 1'b0;
      tick();

      // 1: single requester 2, 3*5
      a_v[2] = 33'd3; b_v[2] = 30'd5;
      req_valid = 4'b0100;
      issue_step(2, "t1");
      chk("t1_data_15", 64'(res_data), 64'd15);
      req_valid = 4'b0000;
      #1;
      chk("t1_idle_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("t1_drain_valid", 64'(res_valid), 64'd0);
      chk("t1_drain_data_kept", 64'(res_data), 64'd15);
      chk("t1_drain_id_kept", 64'(res_id), 64'd2);
      chk("t1_idle_ptr", 64'(dbg_rr_ptr), 64'd3);

      // 2: max operands, requester 1 wins from rr_ptr=3 after wrap
      a_v[1] = {33{1'b1}}; b_v[1] = {30{1'b1}};
      req_valid = 4'b0010;
      issue_step(1, "t2");
      chk("t2_max_product", 64'(res_data), 64'h7FFF_FFFD_C000_0001);

      // 3: full contention, one grant per cycle, no bubbles
      for (int i = 0; i < 4; i++) begin
         a_v[i] = 33'(10 + i);
         b_v[i] = 30'(100 + i);
      end
      req_valid = 4'hF;
      for (int n = 0; n < 6; n++) issue_step(exp_ptr, "t3");
      chk("t3_last_data", 64'(res_data), 64'd1339);

      // 4: backpressure for 5 cycles, slot frozen
      res_ready = 1'b0;
      #1;
      chk("t4_req_ready_blocked", 64'(req_ready), 64'd0);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("t4_hold_valid", 64'(res_valid), 64'd1);
         chk("t4_hold_id", 64'(res_id), 64'd3);
         chk("t4_hold_data", 64'(res_data), 64'd1339);
         chk("t4_hold_req_ready", 64'(req_ready), 64'd0);
         chk("t4_hold_count", 64'(issue_count), 64'(exp_cnt));
      end
      res_ready = 1'b1;
      issue_step(0, "t4_resume");
      chk("t4_resume_data", 64'(res_data), 64'd1000);

      // 5: advance to rr_ptr=3 while full, then async reset mid-cycle
      issue_step(1, "t5_pre");
      issue_step(2, "t5_pre");
      res_ready = 1'b0;
      tick();
      chk("t5_full_before", 64'(res_valid), 64'd1);
      chk("t5_ptr_before", 64'(dbg_rr_ptr), 64'd3);
      #2;
      ap_rst = 1'b1;
      #1;
      chk("t5_async_valid", 64'(res_valid), 64'd0);
      chk("t5_async_req_ready", 64'(req_ready), 64'd0);
      chk("t5_async_count", 64'(issue_count), 64'd0);
      chk("t5_async_ptr", 64'(dbg_rr_ptr), 64'd0);
      chk("t5_async_data", 64'(res_data), 64'd0);
      tick();
      chk("t5_held_valid", 64'(res_valid), 64'd0);
      #2;
      ap_rst    = 1'b0;
      res_ready = 1'b1;
      exp_cnt   = 0;
      exp_ptr   = 0;
      issue_step(0, "t5_after");

      // 6: idle cycles keep rr_ptr, sparse patterns, then counter wrap
      req_valid = 4'b0000;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("t6_idle_ptr", 64'(dbg_rr_ptr), 64'd1);
         chk("t6_idle_valid", 64'(res_valid), 64'd0);
      end
      req_valid = 4'b0001;
      issue_step(0, "t6_wrap_search");
      req_valid = 4'b0000;
      tick();
      chk("t6_idle2_ptr", 64'(dbg_rr_ptr), 64'd1);
      req_valid = 4'b1010;
      issue_step(1, "t6_sparse_a");
      issue_step(3, "t6_sparse_b");
      issue_step(1, "t6_sparse_c");
      req_valid = 4'hF;
      for (int n = 0; n < 12; n++) issue_step(exp_ptr, "t6_fill");
      chk("t6_count32_17", 64'(issue_count), 64'd17);
      chk("t6_count4_wrap", 64'(issue_count4), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit
   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit reached");
   end

endmodule
